// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared execute-stage definitions: multiply sequencer states, ALU Oper
// encodings and ALU operand source-select codes used by the execute muxes.
// No ports (package).
// ----------------------------------------------------------------------------
package ex_pkg;

   // Multiply sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   // ALU Oper encodings
   localparam logic [3:0] OPER_ROL = 4'b0000;
   localparam logic [3:0] OPER_SLL = 4'b0001;
   localparam logic [3:0] OPER_ROR = 4'b0010;
   localparam logic [3:0] OPER_SRL = 4'b0011;
   localparam logic [3:0] OPER_ADD = 4'b0100;
   localparam logic [3:0] OPER_AND = 4'b0101;
   localparam logic [3:0] OPER_OR  = 4'b0110;
   localparam logic [3:0] OPER_XOR = 4'b0111;

   // ALU operand source selects used by the execute stage
   localparam logic [1:0] SRC_RF  = 2'b00;
   localparam logic [1:0] SRC_IMM = 2'b01;
   localparam logic [1:0] SRC_PC  = 2'b10;
   localparam logic [1:0] SRC_MUL = 2'b11;

   // Pack the ALU inversion controls in {invA, invB} order
   function automatic logic [1:0] alu_inv_bits(input logic inv_a, input logic inv_b);
      return {inv_a, inv_b};
   endfunction

endpackage

// File: rtl/ex_mul_dp.sv
// ----------------------------------------------------------------------------
// ex_mul_dp
// Shift-and-add datapath for the multiply sequencer: the {acc_hi, mplr_lo}
// double-width shift register, the captured multiplicand and the iteration
// counter.
//   clk, rst      : clock, async active-high reset
//   load          : capture op_a/op_b, clear accumulator and counter
//   shift         : take one ALU result and shift right by one
//   op_a, op_b    : multiplicand / multiplier
//   alu_out/cout  : shared ALU sum and carry
//   acc_hi        : upper half of the partial product (ALU InA source)
//   mcand         : multiplicand (ALU InB source)
//   mplr_lsb      : current multiplier bit
//   last          : counter is on the final iteration
//   prod_next     : value {acc_hi, mplr_lo} takes at the next shift
// ----------------------------------------------------------------------------
module ex_mul_dp #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_cout,
   output logic [WIDTH-1:0]   acc_hi,
   output logic [WIDTH-1:0]   mcand,
   output logic               mplr_lsb,
   output logic               last,
   output logic [2*WIDTH-1:0] prod_next
);
   import ex_pkg::*;

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] mplr_lo;
   logic [CW-1:0]    cnt;

   // Carry, sum and the remaining multiplier bits form the (2*WIDTH+1)-bit
   // value already shifted right by one; the dropped bit is the consumed
   // multiplier bit.
   assign prod_next = {alu_cout, alu_out, mplr_lo[WIDTH-1:1]};
   assign mplr_lsb  = mplr_lo[0];
   assign last      = (cnt == CW'(WIDTH - 1));

   // Operand capture, per-iteration shift and iteration counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_hi  <= {WIDTH{1'b0}};
         mplr_lo <= {WIDTH{1'b0}};
         mcand   <= {WIDTH{1'b0}};
         cnt     <= {CW{1'b0}};
      end else if (load) begin
         acc_hi  <= {WIDTH{1'b0}};
         mplr_lo <= op_b;
         mcand   <= op_a;
         cnt     <= {CW{1'b0}};
      end else if (shift) begin
         {acc_hi, mplr_lo} <= prod_next;
         cnt               <= cnt + CW'(1);
      end else begin
         acc_hi  <= acc_hi;
         mplr_lo <= mplr_lo;
         mcand   <= mcand;
         cnt     <= cnt;
      end
   end

endmodule

// File: rtl/ex_mul_seq.sv
// ----------------------------------------------------------------------------
// ex_mul_seq
// Multi-cycle unsigned multiply sequencer. Borrows the shared execute ALU
// for one add per multiplier bit and produces a 2*WIDTH-bit product.
//   clk, rst           : clock, async active-high reset
//   start, flush       : request multiply / abort in-flight multiply
//   op_a, op_b         : multiplicand / multiplier
//   alu_out, alu_cout  : shared ALU results
//   alu_own            : this block drives the ALU inputs
//   alu_ina/inb/oper   : ALU operands and operation while owned, else 0
//   alu_cin, alu_inv   : always 0
//   stall              : freeze upstream pipeline registers
//   busy               : LOAD or ITER in progress
//   done               : one-cycle product-valid pulse
//   prod               : product, held until replaced
// ----------------------------------------------------------------------------
module ex_mul_seq #(
   parameter int         WIDTH    = 16,
   parameter logic [3:0] OPER_ADD = ex_pkg::OPER_ADD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_cout,
   output logic               alu_own,
   output logic [WIDTH-1:0]   alu_ina,
   output logic [WIDTH-1:0]   alu_inb,
   output logic [3:0]         alu_oper,
   output logic               alu_cin,
   output logic [1:0]         alu_inv,
   output logic               stall,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   import ex_pkg::*;

   mul_state_t         state;
   logic               accept;
   logic               shift;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   mcand;
   logic               mplr_lsb;
   logic               last;
   logic [2*WIDTH-1:0] prod_next;

   assign accept = (state == IDLE) && start && !flush;
   assign shift  = (state == ITER) && !flush;

   // Issuing instruction must hold in the start cycle itself, before the
   // registered busy flag can rise.
   assign stall = accept | busy;

   ex_mul_dp #(.WIDTH(WIDTH)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .shift     (shift),
      .op_a      (op_a),
      .op_b      (op_b),
      .alu_out   (alu_out),
      .alu_cout  (alu_cout),
      .acc_hi    (acc_hi),
      .mcand     (mcand),
      .mplr_lsb  (mplr_lsb),
      .last      (last),
      .prod_next (prod_next)
   );

   // Sequencer FSM; busy/alu_own/done are registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         alu_own <= 1'b0;
         done    <= 1'b0;
         prod    <= {(2*WIDTH){1'b0}};
      end else begin
         case (state)
            IDLE: begin
               done    <= 1'b0;
               alu_own <= 1'b0;
               if (accept) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            LOAD: begin
               done <= 1'b0;
               if (flush) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  alu_own <= 1'b0;
               end else begin
                  state   <= ITER;
                  busy    <= 1'b1;
                  alu_own <= 1'b1;
               end
            end
            ITER: begin
               if (flush) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  alu_own <= 1'b0;
                  done    <= 1'b0;
               end else if (last) begin
                  // Capture the final shifted value so prod is valid in DONE
                  state   <= DONE;
                  busy    <= 1'b0;
                  alu_own <= 1'b0;
                  done    <= 1'b1;
                  prod    <= prod_next;
               end else begin
                  state   <= ITER;
                  busy    <= 1'b1;
                  alu_own <= 1'b1;
                  done    <= 1'b0;
               end
            end
            DONE: begin
               // flush here is ignored: the done pulse already completed
               state   <= IDLE;
               busy    <= 1'b0;
               alu_own <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               alu_own <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // ALU controls: operands only while owned, zero otherwise
   always_comb begin
      alu_ina  = {WIDTH{1'b0}};
      alu_inb  = {WIDTH{1'b0}};
      alu_oper = 4'b0000;
      alu_cin  = 1'b0;
      alu_inv  = alu_inv_bits(1'b0, 1'b0);
      if (alu_own) begin
         alu_ina  = acc_hi;
         alu_inb  = mplr_lsb ? mcand : {WIDTH{1'b0}};
         alu_oper = OPER_ADD;
      end else begin
         alu_ina  = {WIDTH{1'b0}};
         alu_inb  = {WIDTH{1'b0}};
         alu_oper = 4'b0000;
      end
   end

endmodule
